// File: rtl/seven_segment_value_decoder.sv
// Decodes a multiplexed 4-digit seven-segment display scan into a signed 6-bit value.
// Optional macro SEVEN_SEGMENT_STABLE_FRAME_EN: load only after two consecutive equal good frames.
module seven_segment_value_decoder #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned FRAME_TIMEOUT = 1048576
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic [3:0] anodes,
  input  logic [7:0] cathodes,
  output logic [5:0] value,
  output logic       value_valid,
  output logic       update,
  output logic       frame_error,
  output logic       timeout
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(FRAME_TIMEOUT);

  localparam logic [1:0] K_DIG   = 2'd0;
  localparam logic [1:0] K_MINUS = 2'd1;
  localparam logic [1:0] K_BLANK = 2'd2;
  localparam logic [1:0] K_ILL   = 2'd3;

  // Glyph classifier on lit-segment pattern {g,f,e,d,c,b,a}; returns {kind, digit}.
  function automatic logic [5:0] classify(input logic [6:0] lit);
    case (lit)
      7'h3F:   return {K_DIG, 4'd0};
      7'h06:   return {K_DIG, 4'd1};
      7'h5B:   return {K_DIG, 4'd2};
      7'h4F:   return {K_DIG, 4'd3};
      7'h66:   return {K_DIG, 4'd4};
      7'h6D:   return {K_DIG, 4'd5};
      7'h7D:   return {K_DIG, 4'd6};
      7'h07:   return {K_DIG, 4'd7};
      7'h7F:   return {K_DIG, 4'd8};
      7'h6F:   return {K_DIG, 4'd9};
      7'h40:   return {K_MINUS, 4'd0};
      7'h00:   return {K_BLANK, 4'd0};
      default: return {K_ILL, 4'd0};
    endcase
  endfunction

  logic unused_dp;
  assign unused_dp = cathodes[7];

  logic [3:0]    an_s1_q, an_s1_d, an_s2_q, an_s2_d;
  logic [6:0]    ca_s1_q, ca_s1_d, ca_s2_q, ca_s2_d;
  logic [10:0]   smp_q, smp_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [6:0]    slot_q [4];
  logic [6:0]    slot_d [4];
  logic [3:0]    seen_q, seen_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;
  logic [5:0]    value_q, value_d;
  logic          valid_q, valid_d;
  logic          update_q, update_d;
  logic          ferr_q, ferr_d;
`ifdef SEVEN_SEGMENT_STABLE_FRAME_EN
  logic [5:0]    stab_val_q, stab_val_d;
  logic          stab_have_q, stab_have_d;
`endif

  logic          cand, hold_cont, accept, frame_done;
  logic [1:0]    idx;
  logic [1:0]    kind [4];
  logic [3:0]    dig  [4];
  logic          fr_ok, fr_neg, good;
  logic [6:0]    mag;
  logic [5:0]    new_val;

  // Input synchronizers and settle counter
  always_comb begin
    an_s1_d = anodes;
    an_s2_d = an_s1_q;
    ca_s1_d = cathodes[6:0];
    ca_s2_d = ca_s1_q;
    smp_d   = {an_s2_q, ca_s2_q};
    cand    = $onehot(~an_s2_q);
    hold_cont = (cnt_q != '0) && (smp_d == smp_q);
    if (!cand)
      cnt_d = '0;
    else if (hold_cont)
      cnt_d = (cnt_q == SETTLE_MAX) ? cnt_q : cnt_q + 1'b1;
    else
      cnt_d = SW'(1);
    // Accept once per stable hold: only on the cycle the count first reaches the threshold.
    accept = cand && (cnt_d == SETTLE_MAX) && !(hold_cont && (cnt_q == SETTLE_MAX));
    idx = 2'd0;
    for (int unsigned i = 0; i < 4; i++)
      if (!an_s2_q[i]) idx = i[1:0];
  end

  // Slot capture and frame completion
  always_comb begin
    frame_done = &seen_q;
    seen_d = frame_done ? '0 : seen_q;
    for (int unsigned i = 0; i < 4; i++) slot_d[i] = slot_q[i];
    if (accept) begin
      slot_d[idx] = ~ca_s2_q;
      seen_d[idx] = 1'b1;
    end
  end

  // Frame layout evaluation
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) {kind[i], dig[i]} = classify(slot_q[i]);
    fr_ok  = 1'b0;
    fr_neg = 1'b0;
    mag    = '0;
    if (kind[3] == K_BLANK && kind[2] == K_BLANK && kind[1] == K_BLANK && kind[0] == K_DIG) begin
      fr_ok = 1'b1;
      mag   = 7'(dig[0]);
    end else if (kind[3] == K_BLANK && kind[2] == K_BLANK && kind[1] == K_MINUS &&
                 kind[0] == K_DIG && dig[0] != 4'd0) begin
      fr_ok  = 1'b1;
      fr_neg = 1'b1;
      mag    = 7'(dig[0]);
    end else if (kind[3] == K_BLANK && kind[2] == K_BLANK && kind[1] == K_DIG &&
                 kind[0] == K_DIG && dig[1] != 4'd0) begin
      fr_ok = 1'b1;
      mag   = 7'(dig[1]) * 7'd10 + 7'(dig[0]);
    end else if (kind[3] == K_BLANK && kind[2] == K_MINUS && kind[1] == K_DIG &&
                 kind[0] == K_DIG && dig[1] != 4'd0) begin
      fr_ok  = 1'b1;
      fr_neg = 1'b1;
      mag    = 7'(dig[1]) * 7'd10 + 7'(dig[0]);
    end
    good    = fr_ok && (fr_neg ? (mag <= 7'd32) : (mag <= 7'd31));
    new_val = fr_neg ? 6'(~mag + 7'd1) : mag[5:0];
  end

  // Output registers and frame timer
  always_comb begin
    value_d  = value_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    ferr_d   = 1'b0;
`ifdef SEVEN_SEGMENT_STABLE_FRAME_EN
    stab_val_d  = stab_val_q;
    stab_have_d = stab_have_q;
`endif
    if (frame_done) begin
      if (good) begin
`ifdef SEVEN_SEGMENT_STABLE_FRAME_EN
        if (stab_have_q && stab_val_q == new_val) begin
          value_d  = new_val;
          valid_d  = 1'b1;
          update_d = 1'b1;
        end
        stab_val_d  = new_val;
        stab_have_d = 1'b1;
`else
        value_d  = new_val;
        valid_d  = 1'b1;
        update_d = 1'b1;
`endif
      end else begin
        ferr_d = 1'b1;
`ifdef SEVEN_SEGMENT_STABLE_FRAME_EN
        // An error frame breaks the run of consecutive equal frames.
        stab_have_d = 1'b0;
`endif
      end
    end
    if (frame_done)
      timer_d = '0;
    else
      timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
    timeout_d = !frame_done && (timer_d == TIMER_MAX);
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_q   <= '1;
      an_s2_q   <= '1;
      ca_s1_q   <= '1;
      ca_s2_q   <= '1;
      smp_q     <= '0;
      cnt_q     <= '0;
      for (int unsigned i = 0; i < 4; i++) slot_q[i] <= '0;
      seen_q    <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      update_q  <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef SEVEN_SEGMENT_STABLE_FRAME_EN
      stab_val_q  <= '0;
      stab_have_q <= 1'b0;
`endif
    end else begin
      an_s1_q   <= an_s1_d;
      an_s2_q   <= an_s2_d;
      ca_s1_q   <= ca_s1_d;
      ca_s2_q   <= ca_s2_d;
      smp_q     <= smp_d;
      cnt_q     <= cnt_d;
      for (int unsigned i = 0; i < 4; i++) slot_q[i] <= slot_d[i];
      seen_q    <= seen_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      update_q  <= update_d;
      ferr_q    <= ferr_d;
`ifdef SEVEN_SEGMENT_STABLE_FRAME_EN
      stab_val_q  <= stab_val_d;
      stab_have_q <= stab_have_d;
`endif
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign update      = update_q;
  assign frame_error = ferr_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_seven_segment_value_decoder.sv
// Directed bench for seven_segment_value_decoder: scans glyph frames and checks decoded results.
module tb_seven_segment_value_decoder;

  localparam int TMO = 300;

  // Active-low cathode patterns, DP off
  localparam logic [7:0] GB = 8'hFF;
  localparam logic [7:0] GM = 8'hBF;
  localparam logic [7:0] G0 = 8'hC0, G1 = 8'hF9, G2 = 8'hA4, G3 = 8'hB0, G4 = 8'h99;
  localparam logic [7:0] G5 = 8'h92, G6 = 8'h82, G7 = 8'hF8, G8 = 8'h80, G9 = 8'h90;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] anodes = 4'hF;
  logic [7:0] cathodes = 8'hFF;
  logic [5:0] value;
  logic       value_valid, update, frame_error, timeout;

  int passes = 0;
  int total  = 0;
  bit upd, err;

  seven_segment_value_decoder #(.SETTLE_CYCLES(4), .FRAME_TIMEOUT(TMO)) dut (
    .clk_100MHz (clk),
    .rst_n      (rst_n),
    .anodes     (anodes),
    .cathodes   (cathodes),
    .value      (value),
    .value_valid(value_valid),
    .update     (update),
    .frame_error(frame_error),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_slot(input int idx, input logic [7:0] g, input int hold);
    @(negedge clk);
    anodes = 4'hF;
    anodes[idx] = 1'b0;
    cathodes = g;
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    anodes = 4'hF;
    cathodes = 8'hFF;
  endtask

  task automatic scan(input logic [7:0] g3, g2, g1, g0, input int hold);
    drive_slot(3, g3, hold);
    drive_slot(2, g2, hold);
    drive_slot(1, g1, hold);
    drive_slot(0, g0, hold);
    idle();
  endtask

  task automatic wait_result(output bit u, output bit e);
    u = 0;
    e = 0;
    repeat (40) begin
      @(negedge clk);
      if (update) u = 1;
      if (frame_error) e = 1;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_value", {2'b0, value}, 8'h00);
    check("rst_valid", {7'b0, value_valid}, 8'h00);
    check("rst_update", {7'b0, update}, 8'h00);
    check("rst_ferr", {7'b0, frame_error}, 8'h00);
    check("rst_timeout", {7'b0, timeout}, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef SEVEN_SEGMENT_STABLE_FRAME_EN
    scan(GB, GB, GB, G5, 6); wait_result(upd, err);
    check("stab5_upd", {7'b0, upd}, 8'h00);
    check("stab5_val", {2'b0, value}, 8'h00);
    check("stab5_valid", {7'b0, value_valid}, 8'h00);
    scan(GB, GB, GB, G9, 6); wait_result(upd, err);
    check("stab9a_upd", {7'b0, upd}, 8'h00);
    scan(GB, GB, GB, G9, 6); wait_result(upd, err);
    check("stab9b_upd", {7'b0, upd}, 8'h01);
    check("stab9b_val", {2'b0, value}, 8'h09);
    check("stab9b_valid", {7'b0, value_valid}, 8'h01);
    scan(GB, GB, GB, G9, 6); wait_result(upd, err);
    check("stab9c_upd", {7'b0, upd}, 8'h01);
    scan(GB, GB, G3, G2, 6); wait_result(upd, err);
    check("stab_err", {7'b0, err}, 8'h01);
    check("stab_err_val", {2'b0, value}, 8'h09);
`else
    scan(GB, GB, GB, G7, 6); wait_result(upd, err);
    check("p7_upd", {7'b0, upd}, 8'h01);
    check("p7_err", {7'b0, err}, 8'h00);
    check("p7_val", {2'b0, value}, 8'h07);
    check("p7_valid", {7'b0, value_valid}, 8'h01);

    scan(GB, GM, G3, G2, 6); wait_result(upd, err);
    check("m32_upd", {7'b0, upd}, 8'h01);
    check("m32_val", {2'b0, value}, 8'h20);

    scan(GB, GB, GM, G0, 6); wait_result(upd, err);
    check("m0_err", {7'b0, err}, 8'h01);
    check("m0_upd", {7'b0, upd}, 8'h00);
    check("m0_val", {2'b0, value}, 8'h20);

    scan(GB, GB, G3, G2, 6); wait_result(upd, err);
    check("p32_err", {7'b0, err}, 8'h01);
    check("p32_val", {2'b0, value}, 8'h20);

    scan(GB, GB, G0, G5, 6); wait_result(upd, err);
    check("p05_err", {7'b0, err}, 8'h01);

    // DP lit on the units digit must not matter
    scan(GB, GB, G3, G1 & 8'h7F, 6); wait_result(upd, err);
    check("p31_upd", {7'b0, upd}, 8'h01);
    check("p31_val", {2'b0, value}, 8'h1F);

    scan(GB, GB, G3, G1, 6); wait_result(upd, err);
    check("p31_again_upd", {7'b0, upd}, 8'h01);
    check("p31_again_err", {7'b0, err}, 8'h00);

    scan(GB, GB, GM, G9, 6); wait_result(upd, err);
    check("m9_val", {2'b0, value}, 8'h37);
    scan(GB, GB, G2, G7, 6); wait_result(upd, err);
    check("p27_val", {2'b0, value}, 8'h1B);
    scan(GB, GM, G1, G9, 6); wait_result(upd, err);
    check("m19_val", {2'b0, value}, 8'h2D);

    scan(GB, G8, GB, G8, 6); wait_result(upd, err);
    check("badlayout_err", {7'b0, err}, 8'h01);
    scan(GB, GB, GB, 8'hAA, 6); wait_result(upd, err);
    check("illegal_err", {7'b0, err}, 8'h01);

    // Slot 1 re-accepted before the frame completes: latest glyph wins
    drive_slot(3, GB, 6);
    drive_slot(2, GB, 6);
    drive_slot(1, G2, 6);
    drive_slot(1, GM, 6);
    drive_slot(0, G6, 6);
    idle();
    wait_result(upd, err);
    check("ovw_upd", {7'b0, upd}, 8'h01);
    check("ovw_val", {2'b0, value}, 8'h3A);

    scan(GB, GB, GB, G4, 3); wait_result(upd, err);
    check("glitch_upd", {7'b0, upd}, 8'h00);
    check("glitch_err", {7'b0, err}, 8'h00);
    check("glitch_val", {2'b0, value}, 8'h3A);
    for (int i = 0; i < 3 * TMO && !timeout; i++) @(negedge clk);
    check("timeout_set", {7'b0, timeout}, 8'h01);
    scan(GB, GB, GB, G8, 6); wait_result(upd, err);
    check("timeout_clr", {7'b0, timeout}, 8'h00);
    check("after_tmo_val", {2'b0, value}, 8'h08);

    drive_slot(3, GB, 6);
    drive_slot(2, GB, 6);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_val", {2'b0, value}, 8'h00);
    check("midrst_valid", {7'b0, value_valid}, 8'h00);
    check("midrst_update", {7'b0, update}, 8'h00);
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    scan(GB, GB, GM, G4, 6); wait_result(upd, err);
    check("m4_upd", {7'b0, upd}, 8'h01);
    check("m4_val", {2'b0, value}, 8'h3C);
    check("m4_valid", {7'b0, value_valid}, 8'h01);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/seven_segment_value_decoder.md
SEVEN_SEGMENT_VALUE_DECODER -- requirements
Module: seven_segment_value_decoder

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: the number of consecutive identical samples needed before a digit glyph is accepted.
REQ-002 SHALL have parameter FRAME_TIMEOUT, default 1048576: the maximum number of cycles allowed to complete a scan frame.
REQ-003 SHALL have port clk_100MHz, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port anodes, input, 4 bits: digit enables AN3..AN0, active-low, asynchronous to the clock.
REQ-006 SHALL have port cathodes, input, 8 bits: segments, active-low; bit0=CA, bit1=CB … bit6=CG, bit7=DP. DP is ignored.
REQ-007 SHALL have port value, output, 6 bits: the decoded two's-complement value.
REQ-008 SHALL have port value_valid, output, 1 bit: level; set once at least one good frame has been decoded.
REQ-009 SHALL have port update, output, 1 bit: one-cycle pulse when value is loaded.
REQ-010 SHALL have port frame_error, output, 1 bit: one-cycle pulse when a completed frame is illegal.
REQ-011 SHALL have port timeout, output, 1 bit: level; no frame completed within FRAME_TIMEOUT.

Function
REQ-012 SHALL pass anodes and cathodes through a two-flop synchronizer before any use; this adds 2 cycles of latency.
REQ-013 SHALL treat a synchronized sample as a candidate only when exactly one anode bit is low; other samples reset the settle counter.
REQ-014 SHALL accept a candidate into digit slot N (N = the low anode index) after SETTLE_CYCLES consecutive identical {anodes, cathodes[6:0]} samples, then mark slot N seen.
REQ-015 SHALL classify each glyph as digit 0-9 (standard segments), MINUS (only CG lit), BLANK (none lit) or ILLEGAL.
REQ-016 SHALL complete a frame on the cycle after all four slots are marked seen; the seen marks clear in that same cycle.
REQ-017 SHALL accept exactly these frame layouts (AN3..AN0):
 - B B B d -> +d
 - B B - d -> -d, with d≠0
 - B B t u -> +(10t+u), with t≥1
 - B - t u -> -(10t+u), with t≥1
 Here B=BLANK, -=MINUS, t/u/d=digits.
REQ-018 SHALL accept magnitudes only in the range 0..31 for positive frames and 1..32 for negative frames; -32 encodes as 6'b100000.
REQ-019 SHALL treat any other layout, any ILLEGAL glyph, or an out-of-range magnitude as an error: pulse frame_error 1 cycle; value, value_valid and update are unchanged.
REQ-020 SHALL, on a good frame, load value, set value_valid and pulse update, all in the same cycle, 1 cycle after frame completion.
REQ-021 SHALL pulse update on every accepted frame, including when the value is unchanged.
REQ-022 SHALL run a frame timer that counts cycles since the last frame completion (good or error) and raises timeout at FRAME_TIMEOUT; timeout clears on the next frame completion.
REQ-023 SHALL overwrite the slot if the same slot is re-accepted before the frame completes; the latest glyph wins.
REQ-024 SHALL NOT load a slot from a candidate whose anode changes mid-settle.

Reset
REQ-025 SHALL, while rst_n=0, drive value=0, value_valid=0, update=0, frame_error=0 and timeout=0.
REQ-026 SHALL, while rst_n=0, clear the synchronizers, settle counter, slots, seen marks and frame timer.
REQ-027 SHALL discard any partial frame when reset asserts mid-frame; decoding restarts from empty slots after release.

Configuration
REQ-028 SHALL, with macro SEVEN_SEGMENT_STABLE_FRAME_EN defined, load value only after two consecutive good frames decode to the same value. A differing good frame becomes the new candidate without update. Errors and timeouts behave as without the macro.
REQ-029 SHALL, without the macro, load value from every good frame per REQ-020.

Verification
REQ-030 Scan "B B B 7", SETTLE_CYCLES=4 → update pulse, value=6'd7, value_valid=1.
REQ-031 Scan "B - 3 2" → value=6'b100000 (-32); then "B B - 0" → frame_error pulse, value stays -32.
REQ-032 Scan "B B 3 2" (+32) → frame_error; "B B 0 5" → frame_error; "B B 3 1" → value=6'd31.
REQ-033 Glitch: each anode held only 3 cycles → no slot accepted; hold anodes idle for FRAME_TIMEOUT cycles → timeout=1; one good frame → timeout=0.
REQ-034 Assert rst_n=0 after 2 of 4 slots accepted → all outputs 0; after release the next full "B B - 4" frame → value=-4 (6'b111100).
REQ-035 With SEVEN_SEGMENT_STABLE_FRAME_EN: frames 5, 9, 9 → no update after 5, no update after the first 9, update after the second 9 with value=9.
